// File: rtl/sfp2fix_align.sv
// rtl/sfp2fix_align.sv - Two-stage SFP group to shared-exponent fixed-point aligner
module sfp2fix_align #(
    parameter int expWidth    = 4,
    parameter int sigWidth    = 4,
    parameter int formatWidth = 9,
    parameter int low_expand  = 2,
    parameter int NUM         = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [NUM*formatWidth-1:0]                   sfp_in,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [NUM*(sigWidth+4+low_expand)-1:0]       fix_out,
    output logic [expWidth-1:0]                          max_exp
);

    // Lane width and aligned-magnitude width (hidden one + fraction + guard bits)
    localparam int W  = sigWidth + 4 + low_expand;
    localparam int MW = sigWidth + 1 + low_expand;

    logic                         s1_v_q, s1_v_d;
    logic [NUM*formatWidth-1:0]   s1_data_q, s1_data_d;
    logic [expWidth-1:0]          s1_max_q, s1_max_d;
    logic                         s2_v_q, s2_v_d;
    logic [NUM*W-1:0]             s2_fix_q, s2_fix_d;
    logic [expWidth-1:0]          s2_max_q, s2_max_d;

    logic                         s1_load;
    logic                         s2_load;
    logic [expWidth-1:0]          grp_max;
    logic [NUM*W-1:0]             fix_calc;
    logic [expWidth-1:0]          op_exp [NUM];
    logic [expWidth-1:0]          shift  [NUM];
    logic [MW-1:0]                mant   [NUM];
    logic [MW-1:0]                mag    [NUM];
    logic [W-1:0]                 lane   [NUM];

    // Handshake and valid-bit bookkeeping for both stages
    always_comb begin
        in_ready = !s1_v_q || !s2_v_q || out_ready;
        s1_load  = in_valid && in_ready;
        s2_load  = s1_v_q && (!s2_v_q || out_ready);

        s1_v_d = s1_v_q;
        if (s1_load) begin
            s1_v_d = 1'b1;
        end else if (s2_load) begin
            s1_v_d = 1'b0;
        end

        s2_v_d = s2_v_q;
        if (s2_load) begin
            s2_v_d = 1'b1;
        end else if (out_ready) begin
            s2_v_d = 1'b0;
        end
    end

    // Stage 1: group maximum exponent; zero operands (exp 0) can never win
    always_comb begin
        grp_max = '0;
        for (int i = 0; i < NUM; i++) begin
            if (sfp_in[i*formatWidth+sigWidth +: expWidth] > grp_max) begin
                grp_max = sfp_in[i*formatWidth+sigWidth +: expWidth];
            end
        end
        s1_data_d = s1_data_q;
        s1_max_d  = s1_max_q;
        if (s1_load) begin
            s1_data_d = sfp_in;
            s1_max_d  = grp_max;
        end
    end

    // Stage 2: right-align each mantissa to the shared exponent, then apply sign
    always_comb begin
        fix_calc = '0;
        for (int i = 0; i < NUM; i++) begin
            op_exp[i] = s1_data_q[i*formatWidth+sigWidth +: expWidth];
            shift[i]  = s1_max_q - op_exp[i];
            mant[i]   = {1'b1, s1_data_q[i*formatWidth +: sigWidth], {low_expand{1'b0}}};
            mag[i]    = (32'(shift[i]) < MW) ? (mant[i] >> shift[i]) : '0;
            if (op_exp[i] == '0) begin
                mag[i] = '0;
            end
            lane[i] = {{(W-MW){1'b0}}, mag[i]};
            // Negating a zero magnitude stays zero, so negative zero needs no special case
            if (s1_data_q[i*formatWidth+formatWidth-1]) begin
                lane[i] = -lane[i];
            end
            fix_calc[i*W +: W] = lane[i];
        end
        s2_fix_d = s2_fix_q;
        s2_max_d = s2_max_q;
        if (s2_load) begin
            s2_fix_d = fix_calc;
            s2_max_d = s1_max_q;
        end
    end

    // Pipeline registers; data is cleared on reset so outputs read zero while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_data_q <= '0;
            s1_max_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_fix_q  <= '0;
            s2_max_q  <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_data_q <= s1_data_d;
            s1_max_q  <= s1_max_d;
            s2_v_q    <= s2_v_d;
            s2_fix_q  <= s2_fix_d;
            s2_max_q  <= s2_max_d;
        end
    end

    assign out_valid = s2_v_q;
    assign fix_out   = s2_fix_q;
    assign max_exp   = s2_max_q;

endmodule

// File: tb/tb_sfp2fix_align.sv
// tb/tb_sfp2fix_align.sv - Scoreboard testbench for sfp2fix_align
module tb_sfp2fix_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] sfp_in;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] fix_out;
    logic [3:0]  max_exp;

    int checks   = 0;
    int failures = 0;
    logic [43:0] exp_q [$];

    sfp2fix_align dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sfp_in    (sfp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fix_out   (fix_out),
        .max_exp   (max_exp)
    );

    always #5 clk = ~clk;

    // Reference: integer arithmetic on default parameters, result {max_exp, fix_out}
    function automatic logic [43:0] model(input logic [35:0] d);
        int mx;
        int e;
        int fr;
        int sh;
        int mag;
        int v;
        logic [39:0] f;
        mx = 0;
        f  = '0;
        for (int i = 0; i < 4; i++) begin
            e = int'(d[i*9+4 +: 4]);
            if (e > mx) mx = e;
        end
        for (int i = 0; i < 4; i++) begin
            e  = int'(d[i*9+4 +: 4]);
            fr = int'(d[i*9 +: 4]);
            v  = 0;
            if (e != 0) begin
                sh  = mx - e;
                mag = (sh >= 7) ? 0 : (((16 + fr) * 4) >> sh);
                v   = d[i*9+8] ? -mag : mag;
            end
            f[i*10 +: 10] = v[9:0];
        end
        return {mx[3:0], f};
    endfunction

    function automatic logic [35:0] rand_group();
        logic [35:0] g;
        for (int i = 0; i < 4; i++) begin
            g[i*9 +: 9] = 9'($urandom_range(0, 511));
        end
        return g;
    endfunction

    // Drives one group into an idle pipeline; returns out_valid one edge after acceptance
    task automatic issue_and_wait(input logic [35:0] data, output logic early_v);
        @(negedge clk);
        in_valid  = 1'b1;
        sfp_in    = data;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 early_v = out_valid;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sfp_in    = '0;
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (fix_out !== 40'h0) begin failures++; $display("FAIL reset_fix_out got=%h want=0", fix_out); end
        checks++; if (max_exp !== 4'h0) begin failures++; $display("FAIL reset_max_exp got=%h want=0", max_exp); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic early;
        issue_and_wait({9'h000, 9'h040, 9'h158, 9'h050}, early);
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL basic_latency_early got=%b want=0", early); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b want=1", out_valid); end
        checks++; if (max_exp !== 4'd5) begin failures++; $display("FAIL basic_max_exp got=%0d want=5", max_exp); end
        checks++; if (fix_out !== {10'h000, 10'h020, 10'h3A0, 10'h040}) begin
            failures++; $display("FAIL basic_fix_out got=%h want=%h", fix_out, {10'h000, 10'h020, 10'h3A0, 10'h040});
        end
    endtask

    task automatic test_truncation();
        logic early;
        issue_and_wait({9'h130, 9'h02F, 9'h05F, 9'h090}, early);
        checks++; if (max_exp !== 4'd9) begin failures++; $display("FAIL trunc_max_exp got=%0d want=9", max_exp); end
        checks++; if (fix_out !== {10'h3FF, 10'h000, 10'h007, 10'h040}) begin
            failures++; $display("FAIL trunc_fix_out got=%h want=%h", fix_out, {10'h3FF, 10'h000, 10'h007, 10'h040});
        end
    endtask

    task automatic test_all_zero();
        logic early;
        issue_and_wait({4{9'h10F}}, early);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL zero_out_valid got=%b want=1", out_valid); end
        checks++; if (max_exp !== 4'd0) begin failures++; $display("FAIL zero_max_exp got=%0d want=0", max_exp); end
        checks++; if (fix_out !== 40'h0) begin failures++; $display("FAIL zero_fix_out got=%h want=0", fix_out); end
    endtask

    task automatic test_back_pressure();
        logic [35:0] grp [5];
        logic [43:0] e;
        logic [39:0] held;
        logic        held_v;
        logic        drop_seen;
        int          sent;
        int          got;
        for (int i = 0; i < 5; i++) grp[i] = {9'h000, 9'h000, 9'(9'h041 + 9'(i)), 9'(9'h150 + 9'(i))};
        sent = 0; got = 0; held_v = 1'b0; drop_seen = 1'b0; held = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            out_ready = (c >= 4);
            in_valid  = (sent < 5);
            sfp_in    = grp[sent < 5 ? sent : 4];
            #1;
            if (!in_ready && !drop_seen) begin
                drop_seen = 1'b1;
                checks++; if (sent != 2) begin failures++; $display("FAIL bp_in_ready_drop got=%0d want=2", sent); end
            end
            if (out_valid && !out_ready) begin
                if (held_v) begin
                    checks++; if (fix_out !== held) begin failures++; $display("FAIL bp_hold got=%h want=%h", fix_out, held); end
                end
                held = fix_out; held_v = 1'b1;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(sfp_in));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL bp_unexpected_output got=%h want=none", fix_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({max_exp, fix_out} !== e) begin failures++; $display("FAIL bp_data got=%h want=%h", {max_exp, fix_out}, e); end
                end
                got++;
            end
            if (sent == 5 && got == 5) break;
        end
        in_valid = 1'b0;
        checks++; if (got != 5) begin failures++; $display("FAIL bp_count got=%0d want=5", got); end
        checks++; if (!drop_seen) begin failures++; $display("FAIL bp_in_ready_never_dropped got=1 want=0"); end
        exp_q.delete();
    endtask

    task automatic test_throughput();
        logic [43:0] e;
        int got;
        int first_c;
        int last_c;
        got = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (c < 20);
            sfp_in    = rand_group();
            #1;
            if (in_valid && in_ready) exp_q.push_back(model(sfp_in));
            if (out_valid && out_ready) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL tp_unexpected_output got=%h want=none", fix_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({max_exp, fix_out} !== e) begin failures++; $display("FAIL tp_data got=%h want=%h", {max_exp, fix_out}, e); end
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (got != 20) begin failures++; $display("FAIL tp_count got=%0d want=20", got); end
        checks++; if (last_c - first_c + 1 != 20) begin failures++; $display("FAIL tp_consecutive got=%0d want=20", last_c - first_c + 1); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_stream();
        logic early;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sfp_in    = {9'h000, 9'h000, 9'h000, 9'h050};
        @(posedge clk);
        @(negedge clk);
        sfp_in = {9'h000, 9'h000, 9'h000, 9'h090};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_precond got=%b want=1", out_valid); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); end
        checks++; if (fix_out !== 40'h0) begin failures++; $display("FAIL rst_mid_fix_out got=%h want=0", fix_out); end
        @(negedge clk);
        rst_n = 1'b1;
        issue_and_wait({9'h000, 9'h040, 9'h158, 9'h050}, early);
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL rst_mid_early got=%b want=0", early); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_new_valid got=%b want=1", out_valid); end
        checks++; if ({max_exp, fix_out} !== {4'd5, 10'h000, 10'h020, 10'h3A0, 10'h040}) begin
            failures++; $display("FAIL rst_mid_new_data got=%h want=%h", {max_exp, fix_out}, {4'd5, 10'h000, 10'h020, 10'h3A0, 10'h040});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncation();
        test_all_zero();
        test_back_pressure();
        test_throughput();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
